// File: rtl/cas_byte_encoder.sv
// Cassette byte serializer: shifts bytes LSB-first onto the tone-select line,
// switching tone only on completed square-wave cycles of the downstream generator.
module cas_byte_encoder #(
  parameter int   WIDTH     = 8,
  parameter int   HALF_CYC  = 2,
  parameter logic IDLE_FREQ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             s_in,
  output logic             freq,
  output logic             busy,
  output logic [2:0]       bit_idx
);

  localparam int             TW       = (HALF_CYC > 2) ? $clog2(HALF_CYC) : 1;
  localparam logic [TW-1:0]  TOG_LAST = TW'(HALF_CYC - 1);
  localparam logic [2:0]     BIT_LAST = 3'(WIDTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_n;
  logic             s_meta, s_sync, s_prev;
  logic             s_edge, s_rise;
  logic             hold_full, hold_full_n;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shift, shift_n;
  logic             freq_n;
  logic [2:0]       bit_n;
  logic [TW-1:0]    tog_cnt, tog_n;
  logic             accept;

  // Synchronizer resets to the generator's square reset level so no false edge follows reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= s_in;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign s_edge = s_sync ^ s_prev;
  assign s_rise = s_sync & ~s_prev;
  assign accept = din_valid & ~hold_full;

  always_ff @(posedge clk) begin
    if (accept) hold <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      freq      <= IDLE_FREQ;
      hold_full <= 1'b0;
      bit_idx   <= 3'd0;
      tog_cnt   <= '0;
      shift     <= '0;
    end else begin
      state     <= state_n;
      freq      <= freq_n;
      hold_full <= hold_full_n;
      bit_idx   <= bit_n;
      tog_cnt   <= tog_n;
      shift     <= shift_n;
    end
  end

  always_comb begin
    state_n     = state;
    freq_n      = freq;
    shift_n     = shift;
    bit_n       = bit_idx;
    tog_n       = tog_cnt;
    hold_full_n = hold_full | accept;
    case (state)
      IDLE: begin
        freq_n = IDLE_FREQ;
        if (s_rise && hold_full) begin
          shift_n     = hold;
          hold_full_n = 1'b0;
          bit_n       = 3'd0;
          tog_n       = '0;
          freq_n      = hold[0];
          state_n     = SEND;
        end
      end
      SEND: begin
        if (s_edge) begin
          if (tog_cnt == TOG_LAST) begin
            // Bit boundary always falls on a rising edge since HALF_CYC is even
            tog_n = '0;
            if (bit_idx < BIT_LAST) begin
              shift_n = shift >> 1;
              bit_n   = bit_idx + 3'd1;
              freq_n  = shift[1];
            end else if (hold_full) begin
              shift_n     = hold;
              hold_full_n = 1'b0;
              bit_n       = 3'd0;
              freq_n      = hold[0];
            end else begin
              freq_n  = IDLE_FREQ;
              state_n = IDLE;
            end
          end else begin
            tog_n = tog_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign din_ready = ~hold_full;
  assign busy      = (state == SEND) | hold_full;

endmodule

// File: tb/tb_cas_byte_encoder.sv
// Randomized bench for cas_byte_encoder: a tone-generator model drives s_in and a
// bit-queue reference model predicts freq, din_ready, busy and bit_idx every cycle.
module tb_cas_byte_encoder;

  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       s_in = 1'b1;
  logic       din_ready, freq, busy;
  logic [2:0] bit_idx;

  always #5 clk = ~clk;

  cas_byte_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .s_in      (s_in),
    .freq      (freq),
    .busy      (busy),
    .bit_idx   (bit_idx)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Tone generator: toggles s_in every tf clk on the fast tone, every 2*tf on the slow tone
  int tf = 100;
  bit gen_en = 1'b1;
  int gcnt = 0;
  initial forever begin
    @(negedge clk);
    if (gen_en) begin
      gcnt++;
      if (gcnt >= (freq ? tf : 2 * tf)) begin
        s_in = ~s_in;
        gcnt = 0;
      end
    end
  end

  // Reference: a byte in flight (m_cur/m_idx) plus a one-byte holding slot; bits advance
  // on each s_in rise as seen through the two-flop synchronizer
  bit       m_send = 1'b0, m_hv = 1'b0;
  logic [7:0] m_cur = 8'h00, m_hold = 8'h00;
  int       m_idx = 0;
  bit       p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;
  bit       m_acc, m_rise;
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_send = 1'b0;
      m_hv   = 1'b0;
      m_idx  = 0;
      p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
    end else begin
      m_acc  = din_valid && !m_hv;
      m_rise = p2 && !p3;
      if (m_rise) begin
        if (m_send && m_idx < 7) m_idx++;
        else if (m_hv) begin
          m_send = 1'b1;
          m_cur  = m_hold;
          m_idx  = 0;
          m_hv   = 1'b0;
        end else m_send = 1'b0;
      end
      if (m_acc) begin
        m_hold = din;
        m_hv   = 1'b1;
      end
      p3 = p2; p2 = p1; p1 = s_in;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("freq", freq, m_send ? m_cur[m_idx] : 1'b1);
    chk("din_ready", din_ready, !m_hv);
    chk("busy", busy, m_send || m_hv);
    if (m_send) chk("bit_idx", bit_idx, m_idx);
  end

  // Offer a byte; while not ready, din carries junk with din_valid held high
  task automatic push(input logic [7:0] b);
    int n = 0;
    while (din_ready !== 1'b1 && n < LIMIT) begin
      din = 8'($urandom);
      din_valid = 1'b1;
      @(negedge clk);
      n++;
    end
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din = 8'($urandom);
    chk("push_wait_ok", 32'(n < LIMIT), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || m_send || m_hv) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_ok", 32'(n < LIMIT), 1);
  endtask

  logic       f0;
  logic [2:0] b0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_freq", freq, 1);
    chk("rst_ready", din_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_idx", bit_idx, 0);
    reset = 1'b0;

    repeat (1000) @(negedge clk);

    push(8'hA5);
    wait_idle();

    tf = 20;
    push(8'h00);
    push(8'hFF);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    begin
      int n = 0;
      push(8'($urandom));
      while (!(busy === 1'b1 && bit_idx == 3'd3) && n < LIMIT) begin
        @(negedge clk);
        n++;
      end
      chk("freeze_reach_ok", 32'(n < LIMIT), 1);
    end
    repeat (4) @(negedge clk);
    gen_en = 1'b0;
    repeat (5) @(negedge clk);
    f0 = freq;
    b0 = bit_idx;
    repeat (10000) @(negedge clk);
    chk("freeze_freq", freq, f0);
    chk("freeze_bit_idx", bit_idx, b0);
    gen_en = 1'b1;
    wait_idle();

    push(8'h3C);
    repeat (150) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrst_freq", freq, 1);
    chk("midrst_ready", din_ready, 1);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(8'h96);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cas_byte_encoder.md
Name: cas_byte_encoder

Overview:
- Cassette-output byte serializer that sits directly upstream of the cassette square-wave generator.
- Accepts bytes over a valid/ready handshake and serializes them LSB-first onto the generator's `freq` select line: 0 = slow tone, 1 = fast tone.
- Watches the generator's square output `s_in` so that every `freq` change lands on a completed waveform cycle (rising edge of the square). Each bit is therefore exactly one whole cycle of its tone, with no glitch or partial cycle.

Parameters:
- WIDTH, 8, bits per byte shifted out.
- HALF_CYC, 2, square toggles (both edges counted) per bit; must be even and >=2.
- IDLE_FREQ, 1'b1, value driven on `freq` while no byte is being sent.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  reset; asynchronous, active-high.
- din  input  WIDTH  byte to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  holding register empty; byte accepted when din_valid & din_ready.
- s_in  input  1  square output of generator; asynchronous to clk.
- freq  output  1  tone select to generator.
- busy  output  1  byte in holding register or in shift register.
- bit_idx  output  3  index of the bit currently on freq (debug/verification).

Behaviour:
- Reset, asynchronous: state=IDLE, freq=IDLE_FREQ, hold_full=0, din_ready=1, busy=0, bit_idx=0, tog_cnt=0, shift=0. Both sync flops and s_prev=1, matching the generator's square reset level.
- Input sync:
  - s_in passes through 2 flops to give s_sync; s_prev is s_sync delayed one clk.
  - edge = s_sync ^ s_prev; rise = s_sync & ~s_prev.
  - Latency from s_in change to edge/rise: 2–3 clk, negligible against the kHz tone.
- Holding register:
  - din_ready = ~hold_full (registered).
  - On accept, the byte is captured and hold_full<=1.
  - hold_full clears only on transfer to the shift register.
  - Acceptance and transfer cannot coincide, because accept requires hold_full=0 and transfer requires hold_full=1.
- FSM IDLE:
  - freq=IDLE_FREQ.
  - On rise with hold_full=1: shift<=hold, hold_full<=0, bit_idx<=0, tog_cnt<=0, freq<=hold[0], go to SEND.
  - A byte arriving between rises waits for the next rise.
- FSM SEND:
  - On each edge: tog_cnt<=tog_cnt+1.
  - When edge and tog_cnt==HALF_CYC-1 (bit complete; always a rising edge because HALF_CYC is even): tog_cnt<=0, then:
    - bit_idx<WIDTH-1: shift right, bit_idx++, freq<=next bit.
    - bit_idx==WIDTH-1 and hold_full=1: gapless reload as in IDLE (freq<=hold[0], bit_idx<=0), stay in SEND.
    - bit_idx==WIDTH-1 and hold_full=0: freq<=IDLE_FREQ, go to IDLE.
- freq changes only in the clk following a qualifying edge; it never changes mid-cycle.
- busy = (state==SEND) | hold_full.
- tog_cnt width is clog2(HALF_CYC); it must never wrap within a bit.
- s_in stuck (no edges): FSM holds its state indefinitely; there is no timeout.
- Reset mid-byte: the byte in flight and the held byte are discarded; freq returns to IDLE_FREQ immediately.
- din_valid while din_ready=0: ignored; din is not sampled.

Test Plan:
- Reset, then idle with s_in toggling every 100 clk -> freq=1, din_ready=1, busy=0 throughout; a reset asserted mid-bit forces freq=1 within the same cycle.
- Send 0xA5 with s_in modelled as generator (toggle period 200 clk when freq=0, 100 when freq=1) -> freq sequence 1,0,1,0,0,1,0,1. Each bit spans exactly 2 toggles ending on a rise. freq returns to 1, then busy=0.
- Present 0x00 then 0xFF back-to-back, second byte accepted while the first is sending -> din_ready drops after first accept, reasserts at first-byte load. freq has no idle cycle between bit 7 of 0x00 and bit 0 of 0xFF.
- Hold din_valid=1 with din changing while din_ready=0 -> only values sampled at accept cycles are transmitted.
- Assert din_valid just after a rise in IDLE -> freq stays 1 until the next rise, then takes din[0] within 3 clk of that s_in edge.
- Freeze s_in mid-byte for 10000 clk -> freq and bit_idx stable; on resume, transmission continues from the same bit.
